simon_key_schedule: RTL and testbench

- Sequential round-key generator for the SIMON cipher (default SIMON32/64).
- Loads an M-word master key into a word shift register and instantiates SIMON_keyexpansion to derive each new word.
- Streams round keys k0..k(T-1) one per handshake to the downstream round-function datapath.
- Sits between key-input logic and the SIMON round core.

---
 rtl/simon_pkg.sv | 10 +
 rtl/simon_key_schedule_keyexpansion.sv | 22 ++
 rtl/simon_key_schedule.sv | 74 +++++++
 tb/tb_simon_key_schedule.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared SIMON32/64 defaults, z0 sequence, round constant and FSM states
package simon_pkg;
  localparam int N_DEF = 16;
  localparam int M_DEF = 4;
  localparam int T_DEF = 32;
  // Bit i is the z0 sequence bit used when deriving k[i+M].
  localparam logic [61:0] Z0 = 62'h19C3522FB386A45F;
  localparam int RC = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/simon_key_schedule_keyexpansion.sv
// SIMON_keyexpansion: combinational derivation of k[count+M] from the current M-word window
module SIMON_keyexpansion
  import simon_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int T = T_DEF
) (
  input  logic [$clog2(T)-1:0] count,
  input  logic [M-1:0][N-1:0]  keys,
  output logic [N-1:0]         out
);
  logic [N-1:0] r3, t, t1;
  logic [5:0]   zi;
  always_comb begin
    r3  = {keys[M-1][2:0], keys[M-1][N-1:3]};
    t   = (M == 4) ? r3 ^ keys[1] : r3;
    t1  = t ^ {t[0], t[N-1:1]};
    zi  = 6'(32'(count) % 62);
    out = ~keys[0] ^ t1 ^ N'(RC) ^ N'(Z0[zi]);
  end
endmodule

// File: rtl/simon_key_schedule.sv
// simon_key_schedule: streams SIMON round keys k0..k(T-1) over a valid/ready handshake.
// Optional SIMON_KEY_REPLAY_EN adds a replay input that restarts from a stored master key.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int T = T_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
`ifdef SIMON_KEY_REPLAY_EN
  input  logic                 replay,
`endif
  input  logic [M*N-1:0]       key_in,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [N-1:0]         rk_out,
  output logic [$clog2(T)-1:0] rk_index,
  output logic                 done
);
  state_t                   state, state_n;
  logic [M-1:0][N-1:0]      keys, keys_n;
  logic [$clog2(T)-1:0]     count, count_n;
  logic [N-1:0]             exp_word;
  logic [M*N-1:0]           src;
  logic                     start;
`ifdef SIMON_KEY_REPLAY_EN
  logic [M*N-1:0] master;
  always_ff @(posedge clk)
    if (rst) master <= '0;
    else if (key_load) master <= key_in;
  assign start = key_load | (replay & (state != IDLE));
  assign src   = key_load ? key_in : master;
`else
  assign start = key_load;
  assign src   = key_in;
`endif
  SIMON_keyexpansion #(.N(N), .M(M), .T(T)) u_exp (
    .count(count),
    .keys (keys),
    .out  (exp_word)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      keys  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      keys  <= keys_n;
      count <= count_n;
    end
  // The final transfer leaves the window unshifted so rk_out keeps the last key in DONE.
  always_comb begin
    state_n = state;
    keys_n  = keys;
    count_n = count;
    if (start) begin
      state_n = RUN;
      keys_n  = src;
      count_n = '0;
    end else if (state == RUN && rk_ready) begin
      state_n = (count == ($clog2(T))'(T-1)) ? DONE : RUN;
      keys_n  = (count == ($clog2(T))'(T-1)) ? keys : {exp_word, keys[M-1:1]};
      count_n = (count == ($clog2(T))'(T-1)) ? count : count + 1'b1;
    end
  end
  assign rk_valid = state == RUN;
  assign done     = state == DONE;
  assign rk_out   = keys[0];
  assign rk_index = count;
endmodule

// File: tb/tb_simon_key_schedule.sv
// tb_simon_key_schedule: table, directed and randomized checks against a SIMON32/64 key model
module tb_simon_key_schedule;
  localparam logic [63:0] GOLD = 64'h1918_1110_0908_0100;
  logic        clk = 0, rst = 1, key_load = 0, rk_ready = 0;
  logic        rk_valid, done;
  logic [63:0] key_in = '0;
  logic [15:0] rk_out;
  logic [4:0]  rk_index;
`ifdef SIMON_KEY_REPLAY_EN
  logic        replay = 0;
`endif
  int          checks = 0, passed = 0;
  logic [15:0] mk [32];
  string       zs = "11111010001001010110000111001101111101000100101011000011100110";
  typedef struct {logic [15:0] rk; int idx;} vec_t;
  vec_t        tbl [8];

  simon_key_schedule dut (
    .clk     (clk),
    .rst     (rst),
    .key_load(key_load),
`ifdef SIMON_KEY_REPLAY_EN
    .replay  (replay),
`endif
    .key_in  (key_in),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_out  (rk_out),
    .rk_index(rk_index),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] ror(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  // Reference schedule straight from the SIMON definition with c = 2^16 - 4.
  task automatic build(input logic [63:0] k);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) mk[i] = k[i*16 +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(mk[i-1], 3) ^ mk[i-3];
      t = t ^ ror(t, 1);
      mk[i] = 16'hfffc ^ mk[i-4] ^ t ^ {15'd0, zs[i-4] == "1"};
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [63:0] k);
    key_in = k;
    key_load = 1;
    tick();
    key_load = 0;
  endtask

  task automatic stream(input int pct);
    int idx = 0, cyc = 0;
    logic r;
    while (idx < 32 && cyc < 1000) begin
      r = $urandom_range(0, 99) < pct;
      rk_ready = r;
      chk("stream_valid", 32'(rk_valid), 1);
      chk("stream_rk_out", 32'(rk_out), 32'(mk[idx]));
      chk("stream_rk_index", 32'(rk_index), idx);
      tick();
      cyc++;
      if (r) idx++;
    end
    chk("stream_complete", idx, 32);
    chk("done_set", 32'(done), 1);
    chk("valid_clear_in_done", 32'(rk_valid), 0);
    chk("last_key_held", 32'(rk_out), 32'(mk[31]));
    chk("last_index_held", 32'(rk_index), 31);
  endtask

  initial begin
    tbl[0] = '{16'h0100, 0}; tbl[1] = '{16'h0908, 1};
    tbl[2] = '{16'h1110, 2}; tbl[3] = '{16'h1918, 3};
    tbl[4] = '{16'h71c3, 4}; tbl[5] = '{16'hb649, 5};
    tbl[6] = '{16'h56d4, 6}; tbl[7] = '{16'he070, 7};
    tick();
    tick();
    chk("reset_valid", 32'(rk_valid), 0);
    chk("reset_rk_out", 32'(rk_out), 0);
    chk("reset_index", 32'(rk_index), 0);
    chk("reset_done", 32'(done), 0);
    rst = 0;
    tick();
    chk("idle_valid", 32'(rk_valid), 0);
    // Golden schedule: published vector for the first eight, model for the rest.
    build(GOLD);
    rk_ready = 1;
    load(GOLD);
    for (int i = 0; i < 8; i++) begin
      chk("gold_model", 32'(mk[i]), 32'(tbl[i].rk));
      chk("gold_rk_out", 32'(rk_out), 32'(tbl[i].rk));
      chk("gold_index", 32'(rk_index), tbl[i].idx);
      chk("gold_valid", 32'(rk_valid), 1);
      tick();
    end
    for (int i = 8; i < 32; i++) begin
      chk("gold_rk_out", 32'(rk_out), 32'(mk[i]));
      chk("gold_index", 32'(rk_index), i);
      chk("gold_done_low", 32'(done), 0);
      tick();
    end
    chk("gold_done", 32'(done), 1);
    chk("gold_valid_low", 32'(rk_valid), 0);
    chk("gold_last", 32'(rk_out), 32'(mk[31]));
    rk_ready = 0;
    tick();
    tick();
    chk("done_held", 32'(done), 1);
    // Backpressure at index 4.
    rk_ready = 1;
    load(GOLD);
    chk("reload_done_clear", 32'(done), 0);
    repeat (4) tick();
    rk_ready = 0;
    repeat (5) begin
      chk("bp_rk_out", 32'(rk_out), 16'h71c3);
      chk("bp_index", 32'(rk_index), 4);
      chk("bp_valid", 32'(rk_valid), 1);
      tick();
    end
    rk_ready = 1;
    chk("bp_hold_last", 32'(rk_out), 16'h71c3);
    tick();
    chk("bp_resume_rk", 32'(rk_out), 16'hb649);
    chk("bp_resume_index", 32'(rk_index), 5);
    // Re-key at index 10; the whole new schedule must follow.
    load(GOLD);
    repeat (10) tick();
    chk("rekey_at10", 32'(rk_index), 10);
    begin
      logic [63:0] nk = {$urandom, $urandom};
      build(nk);
      load(nk);
      chk("rekey_index", 32'(rk_index), 0);
      chk("rekey_rk_out", 32'(rk_out), 32'(nk[15:0]));
      stream(100);
    end
    // key_load concurrent with a transfer at index 3.
    build(GOLD);
    rk_ready = 1;
    load(GOLD);
    repeat (3) tick();
    chk("simul_at3", 32'(rk_index), 3);
    begin
      logic [63:0] nk = {$urandom, $urandom};
      build(nk);
      load(nk);
      chk("simul_index", 32'(rk_index), 0);
      chk("simul_rk_out", 32'(rk_out), 32'(mk[0]));
      tick();
      chk("simul_next_index", 32'(rk_index), 1);
      chk("simul_next_rk", 32'(rk_out), 32'(mk[1]));
    end
    // Randomized keys with random backpressure.
    for (int n = 0; n < 4; n++) begin
      logic [63:0] nk = {$urandom, $urandom};
      build(nk);
      rk_ready = 0;
      load(nk);
      stream(60);
    end
    // Reset at index 7 beats a simultaneous key_load.
    rk_ready = 1;
    load(GOLD);
    repeat (7) tick();
    chk("rst_at7", 32'(rk_index), 7);
    rst = 1;
    key_load = 1;
    tick();
    rst = 0;
    key_load = 0;
    chk("rst_valid", 32'(rk_valid), 0);
    chk("rst_rk_out", 32'(rk_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_index", 32'(rk_index), 0);
    tick();
    chk("rst_idle_valid", 32'(rk_valid), 0);
`ifdef SIMON_KEY_REPLAY_EN
    build(GOLD);
    load(GOLD);
    stream(100);
    replay = 1;
    tick();
    replay = 0;
    stream(80);
    rst = 1;
    tick();
    rst = 0;
    replay = 1;
    tick();
    replay = 0;
    chk("replay_idle_valid", 32'(rk_valid), 0);
    tick();
    chk("replay_idle_valid2", 32'(rk_valid), 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
